// File: rtl/mcpu_pkg.sv
// Shared MCPU types and widths: the fetch FSM state, the queue entry layout and the default
// word/address widths (these must match the RAM controller's WORD_SIZE and ADDR_WIDTH).
package mcpu_pkg;
  localparam int MCPU_WORD_SIZE  = 8;
  localparam int MCPU_ADDR_WIDTH = 8;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [MCPU_ADDR_WIDTH-1:0] pc;
    logic [MCPU_WORD_SIZE-1:0]  instr;
  } fetch_entry_t;
endpackage

// File: rtl/mcpu_fetch_queue.sv
// Synchronous FIFO; rdata shows the head combinationally, so a push is visible on the next cycle.
// Pushing while full without a pop is dropped. flush empties the queue and overrides push/pop.
module mcpu_fetch_queue #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & !empty;
  assign do_push = push & (!full | do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; the pointers make stale words unreachable.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end
endmodule

// File: rtl/mcpu_fetch_unit.sv
// MCPU fetch stage: a fetched word reaches instr_out the cycle after it is read; the PC holds while
// the prefetch queue is full and undrained. Optional FETCH_COUNT_EN builds the fetch counter.
module mcpu_fetch_unit
  import mcpu_pkg::*;
#(
  parameter int                    WORD_SIZE   = MCPU_WORD_SIZE,
  parameter int                    ADDR_WIDTH  = MCPU_ADDR_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0,
  parameter int                    QUEUE_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic [ADDR_WIDTH-1:0] instraddr,
  input  logic [WORD_SIZE-1:0]  instrrd,
  output logic [WORD_SIZE-1:0]  instr_out,
  output logic [ADDR_WIDTH-1:0] instr_pc,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  input  logic                  redirect,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  input  logic                  halt,
  output logic [15:0]           fetch_count
);
  typedef struct packed {
    logic [ADDR_WIDTH-1:0] pc;
    logic [WORD_SIZE-1:0]  instr;
  } entry_t;

  fetch_state_e                 state, state_nxt;
  logic [ADDR_WIDTH-1:0]        pc;
  logic                         enq, deq;
  logic                         q_full, q_empty;
  logic [$clog2(QUEUE_DEPTH):0] q_count;
  entry_t                       head, last_q, wentry;

  assign instraddr   = pc;
  assign instr_valid = (q_count != '0);
  assign deq         = instr_valid & instr_ready;
  assign wentry      = '{pc: pc, instr: instrrd};

  always_comb begin
    state_nxt = state;
    enq       = 1'b0;
    case (state)
      RUN: begin
        if (!redirect) begin
          if (halt) state_nxt = HALTED;
          else      enq       = !q_full | deq;
        end
      end
      HALTED: begin
        if (redirect) state_nxt = RUN;
      end
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= RUN;
      pc    <= RESET_PC;
    end else begin
      state <= state_nxt;
      if (redirect) pc <= redirect_pc;
      else if (enq) pc <= pc + ADDR_WIDTH'(1);
    end
  end

  mcpu_fetch_queue #(
    .DEPTH (QUEUE_DEPTH),
    .WIDTH ($bits(entry_t))
  ) u_queue (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (enq),
    .pop   (deq),
    .flush (redirect),
    .wdata (wentry),
    .rdata (head),
    .full  (q_full),
    .empty (q_empty),
    .count (q_count)
  );

  // The FIFO head is meaningless once drained, so the last shown entry is held instead.
  always_ff @(posedge clk) begin
    if (!rst_n)        last_q <= '0;
    else if (!q_empty) last_q <= head;
  end

  assign instr_out = q_empty ? last_q.instr : head.instr;
  assign instr_pc  = q_empty ? last_q.pc    : head.pc;

`ifdef FETCH_COUNT_EN
  logic [15:0] fcnt;
  always_ff @(posedge clk) begin
    if (!rst_n)   fcnt <= '0;
    else if (enq) fcnt <= fcnt + 16'd1;
  end
  assign fetch_count = fcnt;
`else
  assign fetch_count = '0;
`endif
endmodule

// File: tb/tb_mcpu_fetch_unit.sv
// Bench for mcpu_fetch_unit: directed scenarios plus a negedge scoreboard of expected fetch entries.
module tb_mcpu_fetch_unit;
  logic        clk;
  logic        rst_n;
  logic [7:0]  instraddr;
  logic [7:0]  instrrd;
  logic [7:0]  instr_out;
  logic [7:0]  instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        redirect;
  logic [7:0]  redirect_pc;
  logic        halt;
  logic [15:0] fetch_count;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] mem [256];
  assign instrrd = mem[instraddr];

  mcpu_fetch_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instraddr   (instraddr),
    .instrrd     (instrrd),
    .instr_out   (instr_out),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .halt        (halt),
    .fetch_count (fetch_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: {pc, word} pushed when a fetch is expected, popped when decode takes it.
  logic [15:0] mq[$];
  logic [7:0]  mpc;
  logic [15:0] mcnt;
  logic [15:0] last_shown;
  logic        mhalted;
  logic        model_ok = 1'b0;

  function automatic logic [15:0] exp_count();
`ifdef FETCH_COUNT_EN
    return mcnt;
`else
    return 16'd0;
`endif
  endfunction

  initial begin
    forever begin
      @(negedge clk);
      if (model_ok) begin
        chk("sb_valid", {31'd0, instr_valid}, {31'd0, mq.size() != 0});
        if (mq.size() != 0) begin
          chk("sb_pc", {24'd0, instr_pc}, {24'd0, mq[0][15:8]});
          chk("sb_out", {24'd0, instr_out}, {24'd0, mq[0][7:0]});
        end else begin
          chk("hold_pc", {24'd0, instr_pc}, {24'd0, last_shown[15:8]});
          chk("hold_out", {24'd0, instr_out}, {24'd0, last_shown[7:0]});
        end
        chk("sb_addr", {24'd0, instraddr}, {24'd0, mpc});
        chk("sb_count", {16'd0, fetch_count}, {16'd0, exp_count()});
      end
      // Advance the model by the clock edge that comes next.
      if (!rst_n) begin
        mq.delete();
        mpc        = 8'h00;
        mcnt       = 16'd0;
        last_shown = 16'd0;
        mhalted    = 1'b0;
        model_ok   = 1'b1;
      end else if (model_ok) begin
        if (mq.size() != 0) last_shown = mq[0];
        if (redirect) begin
          mq.delete();
          mpc     = redirect_pc;
          mhalted = 1'b0;
        end else begin
          automatic bit take  = (mq.size() != 0) && instr_ready;
          automatic bit fetch = !mhalted && !halt && ((mq.size() < 2) || take);
          if (take) void'(mq.pop_front());
          if (fetch) begin
            mq.push_back({mpc, mem[mpc]});
            mpc  = mpc + 8'd1;
            mcnt = mcnt + 16'd1;
          end
          if (halt) mhalted = 1'b1;
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = i[7:0] ^ 8'hA5;
    rst_n       = 1'b0;
    instr_ready = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 8'h00;
    halt        = 1'b0;
    repeat (2) cyc();
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_addr", {24'd0, instraddr}, 32'd0);
    chk("rst_out", {24'd0, instr_out}, 32'd0);
    chk("rst_pc", {24'd0, instr_pc}, 32'd0);
    chk("rst_count", {16'd0, fetch_count}, 32'd0);

    // Streaming with decode always ready.
    rst_n       = 1'b1;
    instr_ready = 1'b1;
    cyc();
    for (int i = 0; i < 8; i++) begin
      chk("stream_valid", {31'd0, instr_valid}, 32'd1);
      chk("stream_pc", {24'd0, instr_pc}, i);
      chk("stream_out", {24'd0, instr_out}, {24'd0, i[7:0] ^ 8'hA5});
      cyc();
    end

    // Backpressure from reset.
    rst_n       = 1'b0;
    instr_ready = 1'b0;
    cyc();
    rst_n = 1'b1;
    repeat (5) cyc();
    chk("bp_addr", {24'd0, instraddr}, 32'd2);
    chk("bp_valid", {31'd0, instr_valid}, 32'd1);
    instr_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("bp_seq", {24'd0, instr_pc}, i);
      cyc();
    end

    // Redirect with the queue full.
    instr_ready = 1'b0;
    repeat (3) cyc();
    redirect    = 1'b1;
    redirect_pc = 8'h40;
    cyc();
    redirect = 1'b0;
    chk("redir_valid", {31'd0, instr_valid}, 32'd0);
    chk("redir_addr", {24'd0, instraddr}, 32'h40);
    cyc();
    chk("redir_pc", {24'd0, instr_pc}, 32'h40);
    chk("redir_out", {24'd0, instr_out}, {24'd0, 8'h40 ^ 8'hA5});

    // PC wrap.
    instr_ready = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 8'hFE;
    cyc();
    redirect = 1'b0;
    cyc();
    for (int i = 0; i < 4; i++) begin
      automatic logic [7:0] a = 8'hFE + i[7:0];
      chk("wrap_pc", {24'd0, instr_pc}, {24'd0, a});
      cyc();
    end

    // Halt at pc 5, drain, resume via redirect (halt still high).
    instr_ready = 1'b0;
    redirect    = 1'b1;
    redirect_pc = 8'h03;
    cyc();
    redirect = 1'b0;
    repeat (2) cyc();
    chk("halt_pre_addr", {24'd0, instraddr}, 32'd5);
    halt = 1'b1;
    cyc();
    chk("halt_addr", {24'd0, instraddr}, 32'd5);
    instr_ready = 1'b1;
    chk("drain0", {24'd0, instr_pc}, 32'd3);
    cyc();
    chk("drain1", {24'd0, instr_pc}, 32'd4);
    chk("halt_addr2", {24'd0, instraddr}, 32'd5);
    cyc();
    chk("drained_valid", {31'd0, instr_valid}, 32'd0);
    cyc();
    chk("halt_valid", {31'd0, instr_valid}, 32'd0);
    chk("halt_addr3", {24'd0, instraddr}, 32'd5);
    redirect    = 1'b1;
    redirect_pc = 8'h10;
    cyc();
    redirect = 1'b0;
    halt     = 1'b0;
    chk("resume_addr", {24'd0, instraddr}, 32'h10);
    cyc();
    chk("resume_valid", {31'd0, instr_valid}, 32'd1);
    chk("resume_pc", {24'd0, instr_pc}, 32'h10);

    // Reset with the queue full, then count ten fetches.
    instr_ready = 1'b0;
    repeat (3) cyc();
    chk("full_valid", {31'd0, instr_valid}, 32'd1);
    rst_n = 1'b0;
    cyc();
    rst_n       = 1'b1;
    instr_ready = 1'b1;
    chk("mrst_valid", {31'd0, instr_valid}, 32'd0);
    chk("mrst_addr", {24'd0, instraddr}, 32'd0);
    chk("mrst_count", {16'd0, fetch_count}, 32'd0);
    repeat (10) cyc();
`ifdef FETCH_COUNT_EN
    chk("count10", {16'd0, fetch_count}, 32'd10);
`else
    chk("count10", {16'd0, fetch_count}, 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/mcpu_fetch_unit.md
Name: mcpu_fetch_unit

Overview:
- Instruction fetch stage for the MCPU; sits directly upstream of the RAM controller's instruction port.
- Drives the instruction port address (instraddr) from a program counter and takes the returned word (instrrd, combinational read).
- Buffers fetched words in a small prefetch queue and hands them to decode with a valid/ready handshake.
- Supports branch/jump redirect with flush, and halt.

Parameters:
- WORD_SIZE, 8, instruction word width; must equal the RAM controller's WORD_SIZE.
- ADDR_WIDTH, 8, instruction address width; must equal the RAM controller's ADDR_WIDTH.
- RESET_PC, 0, PC value loaded on reset.
- QUEUE_DEPTH, 2, prefetch queue entries; power of two, minimum 2.

Ports:
- clk  in  1  sole clock; all state updates on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- instraddr  out  ADDR_WIDTH  address to the RAM controller instruction port; equals pc.
- instrrd  in  WORD_SIZE  instruction word from the RAM controller, valid in the same cycle as instraddr.
- instr_out  out  WORD_SIZE  instruction at the queue head.
- instr_pc  out  ADDR_WIDTH  address of instr_out.
- instr_valid  out  1  queue non-empty.
- instr_ready  in  1  decode accepts the head entry.
- redirect  in  1  branch/jump taken.
- redirect_pc  in  ADDR_WIDTH  target address when redirect=1.
- halt  in  1  stop fetching.
- fetch_count  out  16  fetched-instruction counter (see Optional Feature).

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - pc=RESET_PC, queue emptied, state=RUN.
  - instr_valid=0, instr_out=0, instr_pc=0, fetch_count=0.
  - Reset takes priority over every other input, including mid-redirect or mid-halt.
- Dequeue: deq = instr_valid & instr_ready. The head entry is removed at the clock edge.
- Enqueue: enq = (state==RUN) & !redirect & (count<QUEUE_DEPTH | deq).
  - When enq=1, the entry {pc, instrrd} is written and pc increments by 1, wrapping from 2^ADDR_WIDTH-1 to 0.
  - Fetch latency: a word is fetched in cycle N and appears on instr_out in cycle N+1 if the queue was empty.
- Full queue: no enqueue and pc holds, unless a dequeue happens in the same cycle; then enqueue and dequeue both occur and count is unchanged.
- Empty queue: instr_valid=0. instr_out and instr_pc hold their last values, and decode must ignore them.
- Redirect (highest priority after reset):
  - Queue flushed, pc=redirect_pc, no enqueue that cycle, fetch_count not incremented.
  - A dequeue in the same cycle is void, because the head is discarded.
  - Any HALTED state exits to RUN.
- FSM states:
  - RUN: fetching. Go to HALTED when halt=1 and redirect=0; no enqueue occurs in that cycle.
  - HALTED: no enqueue, pc frozen, queue keeps draining to decode. Go to RUN only on redirect=1 (halt=1 in the same cycle is ignored) or on reset.
- instraddr always equals pc, whatever the state.
- Queue order is strict FIFO; wrap-around of the queue pointers is invisible to outputs.

Optional Feature:
- Macro FETCH_COUNT_EN.
- Defined: fetch_count increments by 1 on every cycle with enq=1, wraps at 2^16 to 0, and is cleared by reset. Redirect does not clear it.
- Undefined: counter logic is not built and fetch_count is tied to 0.

Decomposition:
- Shared package mcpu_pkg holds:
  - WORD_SIZE and ADDR_WIDTH defaults, shared with the RAM controller.
  - Fetch FSM state type {RUN, HALTED}.
  - Queue entry type {pc, instr}.
- Natural sub-module: mcpu_fetch_queue, a synchronous FIFO.
  - Parameterised depth and width.
  - Signals: push, pop, flush, full, empty, count.
  - flush has priority over push and pop.

Test Plan:
- Streaming: reset, RAM preloaded with mem[i]=i^8'hA5, instr_ready=1 constant.
  - Expect instr_valid=1 from the 1st cycle after reset.
  - Expect instr_pc=0,1,2,... and instr_out=mem[instr_pc] every cycle.
- Backpressure: instr_ready=0 for 5 cycles after reset.
  - Expect the queue to fill with pc 0,1, then pc/instraddr to hold at 2.
  - After ready=1, expect outputs 0,1,2,3 with no gaps or duplicates.
- Redirect with the queue full: redirect=1, redirect_pc=8'h40.
  - Next cycle expect instr_valid=0 and instraddr=8'h40.
  - The following cycle expect instr_pc=8'h40 and instr_out=mem[8'h40].
- PC wrap: redirect_pc=8'hFE, ready=1.
  - Expect instr_pc sequence FE, FF, 00, 01.
- Halt and resume: halt=1 at pc=5.
  - Expect pc to freeze at 5 and the queue to drain the remaining entries, then instr_valid=0.
  - Then redirect_pc=8'h10: expect fetch to resume at 8'h10.
- Reset mid-operation and counter:
  - Assert rst_n=0 for 1 cycle with the queue full: expect instr_valid=0, instraddr=RESET_PC, and fetch_count=0 next cycle.
  - With FETCH_COUNT_EN defined, 10 accepted fetches give fetch_count=10. Undefined, fetch_count stays 0.
